// File: rtl/divider.sv
// divider: iterative restoring divider, one quotient bit per cycle, signed or unsigned.
// Signed mode divides magnitudes and fixes signs on the final iteration, so results are final when done rises.
module divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             Sign,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_zero,
    output logic             V
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] dq_q, dq_d, bmag_q, bmag_d, pr_q, pr_d;
    logic [WIDTH-1:0] quo_q, quo_d, rem_q, rem_d;
    logic             qneg_q, qneg_d, rneg_q, rneg_d, ovf_q, ovf_d;
    logic             done_q, done_d, dz_q, dz_d, v_q, v_d;
    logic [WIDTH:0]   shifted, trial;
    logic [WIDTH-1:0] qn, rn, amag, bmag_in;
    logic             qbit, accept;

    always_comb begin
        accept  = start && state_q != RUN;
        amag    = (Sign && A[WIDTH-1]) ? -A : A;
        bmag_in = (Sign && B[WIDTH-1]) ? -B : B;
        // 33-bit partial remainder: shift in the next dividend bit, trial-subtract the divisor
        shifted = {pr_q, dq_q[WIDTH-1]};
        trial   = shifted - {1'b0, bmag_q};
        qbit    = !trial[WIDTH];
        qn      = {dq_q[WIDTH-2:0], qbit};
        rn      = qbit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
        state_d = state_q;
        cnt_d   = cnt_q;
        dq_d    = dq_q;
        bmag_d  = bmag_q;
        pr_d    = pr_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        ovf_d   = ovf_q;
        done_d  = 1'b0;
        dz_d    = dz_q;
        v_d     = v_q;
        if (state_q == RUN) begin
            dq_d  = qn;
            pr_d  = rn;
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(WIDTH - 1)) begin
                state_d = DONE;
                done_d  = 1'b1;
                quo_d   = qneg_q ? -qn : qn;
                rem_d   = rneg_q ? -rn : rn;
                v_d     = ovf_q;
            end
        end else if (accept) begin
            dq_d    = amag;
            bmag_d  = bmag_in;
            pr_d    = '0;
            cnt_d   = '0;
            qneg_d  = Sign && (A[WIDTH-1] ^ B[WIDTH-1]);
            rneg_d  = Sign && A[WIDTH-1];
            ovf_d   = Sign && A == {1'b1, {(WIDTH-1){1'b0}}} && B == '1;
            dz_d    = B == '0;
            v_d     = 1'b0;
            done_d  = B == '0;
            state_d = (B == '0) ? DONE : RUN;
            quo_d   = (B == '0) ? '1 : quo_q;
            rem_d   = (B == '0) ? A : rem_q;
        end else begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dq_q    <= '0;
            bmag_q  <= '0;
            pr_q    <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
            dz_q    <= 1'b0;
            v_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dq_q    <= dq_d;
            bmag_q  <= bmag_d;
            pr_q    <= pr_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
            dz_q    <= dz_d;
            v_q     <= v_d;
        end
    end

    assign busy      = state_q == RUN;
    assign done      = done_q;
    assign quotient  = quo_q;
    assign remainder = rem_q;
    assign div_zero  = dz_q;
    assign V         = v_q;
endmodule

// File: tb/tb_divider.sv
// tb_divider: vector table, hand-written timing sequences and random operands against an arithmetic model.
module tb_divider;
    logic        clk = 1'b0;
    logic        reset, start, Sign;
    logic [31:0] A, B;
    logic        busy, done, div_zero, V;
    logic [31:0] quotient, remainder;
    int          n_chk = 0;
    int          n_fail = 0;

    divider #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .Sign(Sign), .A(A), .B(B),
        .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
        .div_zero(div_zero), .V(V)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a, b;
        logic        s;
        logic [31:0] q, r;
        logic        dz, v;
    } vec_t;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Truncating division straight from the arithmetic definition
    function automatic logic [65:0] model(input logic [31:0] a, input logic [31:0] b, input logic s);
        longint sa, sb, q, r;
        if (b == 0) return {32'hFFFFFFFF, a, 1'b1, 1'b0};
        if (!s) return {a / b, a % b, 2'b00};
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'h80000000, 32'h0, 1'b0, 1'b1};
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        q = sa / sb;
        r = sa % sb;
        return {q[31:0], r[31:0], 2'b00};
    endfunction

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                          input logic [31:0] eq, input logic [31:0] er, input logic edz, input logic ev);
        int cyc = 0;
        int nbusy = 0;
        A = a; B = b; Sign = s; start = 1'b1;
        tick;
        start = 1'b0;
        cyc = 1;
        while (done !== 1'b1 && cyc < 40) begin
            if (busy === 1'b1) nbusy++;
            tick;
            cyc++;
        end
        chk("latency", 32'(cyc), (b == 0) ? 32'd1 : 32'd33);
        chk("busy_cycles", 32'(nbusy), (b == 0) ? 32'd0 : 32'd32);
        chk("busy_at_done", 32'(busy), 32'd0);
        chk("quotient", quotient, eq);
        chk("remainder", remainder, er);
        chk("div_zero", 32'(div_zero), 32'(edz));
        chk("V", 32'(V), 32'(ev));
        tick;
        chk("done_pulse", 32'(done), 32'd0);
        chk("held_quotient", quotient, eq);
    endtask

    initial begin
        vec_t        tbl[9];
        logic [65:0] m;
        logic [31:0] ra, rb;
        logic        rs;
        int          ndone;
        tbl[0] = '{32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0, 1'b0};
        tbl[1] = '{32'hFFFFFFF9, 32'd2, 1'b1, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, 1'b0};
        tbl[2] = '{32'h80000000, 32'hFFFFFFFF, 1'b1, 32'h80000000, 32'h0, 1'b0, 1'b1};
        tbl[3] = '{32'h80000000, 32'hFFFFFFFF, 1'b0, 32'h0, 32'h80000000, 1'b0, 1'b0};
        tbl[4] = '{32'd5, 32'd0, 1'b0, 32'hFFFFFFFF, 32'd5, 1'b1, 1'b0};
        tbl[5] = '{32'd5, 32'd0, 1'b1, 32'hFFFFFFFF, 32'd5, 1'b1, 1'b0};
        tbl[6] = '{32'hFFFFFFFF, 32'd1, 1'b0, 32'hFFFFFFFF, 32'h0, 1'b0, 1'b0};
        tbl[7] = '{32'd7, 32'hFFFFFFFE, 1'b1, 32'hFFFFFFFD, 32'd1, 1'b0, 1'b0};
        tbl[8] = '{32'hFFFFFFF9, 32'hFFFFFFFE, 1'b1, 32'd3, 32'hFFFFFFFF, 1'b0, 1'b0};

        // Reset with a start pending: start must be discarded
        reset = 1'b1; start = 1'b1; Sign = 1'b0; A = 32'd100; B = 32'd7;
        tick;
        tick;
        reset = 1'b0; start = 1'b0;
        tick;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_quotient", quotient, 32'd0);
        chk("rst_remainder", remainder, 32'd0);
        chk("rst_div_zero", 32'(div_zero), 32'd0);
        chk("rst_V", 32'(V), 32'd0);

        foreach (tbl[i]) run_op(tbl[i].a, tbl[i].b, tbl[i].s, tbl[i].q, tbl[i].r, tbl[i].dz, tbl[i].v);

        // Start ignored while running, then accepted in the done cycle
        ndone = 0;
        for (int c = 0; c <= 67; c++) begin
            if (done === 1'b1) ndone++;
            if (c == 6) chk("busy_after_ignored_start", 32'(busy), 32'd1);
            if (c == 33 || c == 66) chk("done_cycle", 32'(done), 32'd1);
            if (c == 33) begin
                chk("seq1_quotient", quotient, 32'd14);
                chk("seq1_remainder", remainder, 32'd2);
            end
            if (c == 66) begin
                chk("seq2_quotient", quotient, 32'd3);
                chk("seq2_remainder", remainder, 32'd0);
            end
            start = (c == 0 || c == 5 || c == 33);
            A = (c == 0) ? 32'd100 : 32'd9;
            B = (c == 0) ? 32'd7 : 32'd3;
            Sign = 1'b0;
            tick;
        end
        start = 1'b0;
        chk("seq_done_count", 32'(ndone), 32'd2);

        // Leave nonzero results behind so the abort clearing is visible
        run_op(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0, 1'b0);

        // Reset in cycle 10 aborts the operation
        ndone = 0;
        for (int c = 0; c <= 45; c++) begin
            if (c >= 1 && done === 1'b1) ndone++;
            if (c == 11) begin
                chk("abort_busy", 32'(busy), 32'd0);
                chk("abort_done", 32'(done), 32'd0);
                chk("abort_quotient", quotient, 32'd0);
                chk("abort_remainder", remainder, 32'd0);
                chk("abort_div_zero", 32'(div_zero), 32'd0);
                chk("abort_V", 32'(V), 32'd0);
            end
            start = (c == 0);
            reset = (c == 10);
            A = 32'hFFFFFFFF; B = 32'd1; Sign = 1'b0;
            tick;
        end
        start = 1'b0; reset = 1'b0;
        chk("abort_no_done", 32'(ndone), 32'd0);
        run_op(32'hFFFFFFFF, 32'd1, 1'b0, 32'hFFFFFFFF, 32'd0, 1'b0, 1'b0);

        for (int n = 0; n < 200; n++) begin
            ra = ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom;
            case ($urandom_range(0, 9))
                0: rb = 32'd0;
                1: rb = 32'hFFFFFFFF;
                2: rb = $urandom_range(1, 15);
                3: rb = 32'h80000000;
                default: rb = $urandom;
            endcase
            rs = 1'($urandom_range(0, 1));
            m = model(ra, rb, rs);
            run_op(ra, rb, rs, m[65:34], m[33:2], m[1], m[0]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/divider.md
DIVIDER -- requirements
Module: divider

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand and result width; all values below assume WIDTH=32.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset, input, 1, with synchronous active-high reset.
REQ-004 The block SHALL have port start, input, 1, a request to begin a division, sampled on the clk edge.
REQ-005 The block SHALL have port Sign, input, 1, where 1 selects two's-complement signed and 0 selects unsigned; it is captured with start.
REQ-006 The block SHALL have port A, input, 32, the dividend, captured with start.
REQ-007 The block SHALL have port B, input, 32, the divisor, captured with start.
REQ-008 The block SHALL have port busy, output, 1, high while iterating.
REQ-009 The block SHALL have port done, output, 1, a one-cycle pulse indicating that quotient/remainder/flags are valid.
REQ-010 The block SHALL have port quotient, output, 32, the result quotient, held until the next accepted start.
REQ-011 The block SHALL have port remainder, output, 32, the result remainder, held until the next accepted start.
REQ-012 The block SHALL have port div_zero, output, 1, set when B==0 for the current result.
REQ-013 The block SHALL have port V, output, 1, the signed overflow flag (-2^31 / -1), for the current result.

Function
REQ-014 The block SHALL implement states IDLE, RUN and DONE; reset enters IDLE.
REQ-015 In IDLE or DONE, start=1 SHALL capture A, B and Sign, clear done/div_zero/V, and transition to RUN (or to DONE if B==0).
REQ-016 In RUN, start SHALL be ignored, and operands and mode SHALL NOT change.
REQ-017 Timing: for start high in cycle 0 with B!=0, busy SHALL be high in cycles 1..32 and done SHALL be high in cycle 33 only.
REQ-018 RUN SHALL perform exactly 32 restoring shift-subtract iterations, one quotient bit per cycle, MSB first, on 32-bit magnitudes with a 33-bit partial remainder.
REQ-019 With Sign=1, the block SHALL use magnitudes |A| and |B|; quotient SHALL be negated iff A[31]^B[31], and remainder SHALL take the sign of A (truncating division).
REQ-020 The magnitude of 0x80000000 SHALL be treated as unsigned 2^31, with no loss.
REQ-021 For Sign=1, A=0x80000000 and B=0xFFFFFFFF, the block SHALL produce quotient=0x80000000, remainder=0 and V=1.
REQ-022 In all other cases, V SHALL be 0, and V SHALL always be 0 when Sign=0.
REQ-023 For B==0, busy SHALL stay low, done SHALL pulse in cycle 1, quotient=0xFFFFFFFF, remainder=A unchanged and div_zero=1, regardless of Sign.
REQ-024 Sign correction SHALL be applied before done rises; quotient and remainder SHALL be final whenever done=1.
REQ-025 From DONE with no start, the block SHALL return to IDLE on the next cycle; results SHALL remain held in IDLE.
REQ-026 If start=1 in the done cycle, it SHALL be accepted, and the new operation's cycle 0 SHALL be that done cycle.
REQ-027 Invariant: for every result, A == quotient*B + remainder, modulo 2^32, in the selected mode.
REQ-028 |remainder| < |B| SHALL hold for every result with B!=0.

Reset
REQ-029 With reset=1 at a clk edge, the block SHALL set state=IDLE, busy=0, done=0, quotient=0, remainder=0, div_zero=0 and V=0.
REQ-030 Reset SHALL take priority over start; a start in a reset cycle SHALL be discarded.
REQ-031 Reset during RUN SHALL abort the operation; done SHALL NOT assert for the aborted operation.

Verification
REQ-032 The bench SHALL cover: Sign=0, A=100, B=7, start in cycle 0 -> busy cycles 1..32; done in cycle 33 with quotient=14, remainder=2, V=0, div_zero=0.
REQ-033 The bench SHALL cover: Sign=1, A=0xFFFFFFF9 (-7), B=2 -> quotient=0xFFFFFFFD (-3), remainder=0xFFFFFFFF (-1).
REQ-034 The bench SHALL cover: Sign=1, A=0x80000000, B=0xFFFFFFFF -> quotient=0x80000000, remainder=0, V=1; the same operands with Sign=0 -> quotient=0, remainder=0x80000000, V=0.
REQ-035 The bench SHALL cover: A=5, B=0, Sign in {0,1} -> done in cycle 1, busy never high, quotient=0xFFFFFFFF, remainder=5, div_zero=1.
REQ-036 The bench SHALL cover: start 100/7 and re-pulse start with 9/3 in cycle 5 -> the second start is ignored and cycle 33 gives 14 r 2; then start 9/3 in that done cycle -> done in cycle 66 with quotient=3, remainder=0.
REQ-037 The bench SHALL cover: start 0xFFFFFFFF/1 unsigned and assert reset in cycle 10 -> all outputs 0 from cycle 11 and no done pulse; a following start completes normally with quotient=0xFFFFFFFF, remainder=0.
